var_delay: RTL

Runtime-programmable delay line for sample streams, built as a circular buffer with independent write and read pointers. Each enabled sample is written into the buffer, and the sample from D enabled cycles earlier is read out, with D set at run time. It sits in the PSK datapath wherever a pipeline delay must be matched dynamically, for example when aligning the carrier/symbol-timing branch with the data branch after a loop-latency change. A fixed compile-time delay does not need this block.

---
 rtl/var_delay.sv | 117 +++++++++++
 1 files changed

// File: rtl/var_delay.sv
// Runtime-programmable delay line: circular buffer with independent write/read
// pointers, delay set by a load strobe and clamped to 1..MAX_DELAY.
module var_delay #(
    parameter int WIDTH         = 16,
    parameter int MAX_DELAY     = 64,
    parameter int DEFAULT_DELAY = 4,
    localparam int DW           = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             load,
    input  logic [DW-1:0]    delay_in,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic             valid,
    output logic [DW-1:0]    delay_cur
);

    localparam int AW = $clog2(MAX_DELAY);
    localparam logic [DW-1:0] MAX_D   = DW'(MAX_DELAY);
    localparam logic [DW-1:0] DEF_D   = DW'(DEFAULT_DELAY);
    localparam logic [AW-1:0] WP_LAST = AW'(MAX_DELAY - 1);

    logic [WIDTH-1:0] mem_r [MAX_DELAY];
    logic [AW-1:0]    wp_r;
    logic [DW-1:0]    fc_r;

    logic [DW-1:0]    deff_s;
    logic [DW-1:0]    wp_ext_s;
    logic [AW-1:0]    ra_s;
    logic [AW-1:0]    wp_nxt_s;
    logic [DW-1:0]    fc_nxt_s;
    logic             wr_s;

    function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        if (d == {DW{1'b0}}) begin
            r = {{(DW-1){1'b0}}, 1'b1};
        end else if (d > MAX_D) begin
            r = MAX_D;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Effective delay, wrap-safe read address and next pointer/fill values.
    always_comb begin
        deff_s   = delay_cur;
        ra_s     = {AW{1'b0}};
        wp_nxt_s = wp_r;
        fc_nxt_s = fc_r;
        wr_s     = en & ~flush;
        wp_ext_s = DW'(wp_r);
        if (load) begin
            deff_s = clamp_delay(delay_in);
        end else begin
            deff_s = delay_cur;
        end
        // Adding the complement (MAX - Deff) instead of subtracting avoids underflow.
        if (wp_ext_s >= deff_s) begin
            ra_s = AW'(wp_ext_s - deff_s);
        end else begin
            ra_s = AW'(wp_ext_s + (MAX_D - deff_s));
        end
        if (wp_r == WP_LAST) begin
            wp_nxt_s = {AW{1'b0}};
        end else begin
            wp_nxt_s = wp_r + {{(AW-1){1'b0}}, 1'b1};
        end
        if (fc_r == MAX_D) begin
            fc_nxt_s = MAX_D;
        end else begin
            fc_nxt_s = fc_r + {{(DW-1){1'b0}}, 1'b1};
        end
    end

    // Sample storage; unreset, its contents are gated by the fill counter.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wp_r] <= I;
        end
    end

    // Pointers, fill count, delay register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_r      <= {AW{1'b0}};
            fc_r      <= {DW{1'b0}};
            O         <= {WIDTH{1'b0}};
            valid     <= 1'b0;
            delay_cur <= DEF_D;
        end else begin
            if (load) begin
                delay_cur <= deff_s;
            end
            if (flush) begin
                fc_r  <= {DW{1'b0}};
                O     <= {WIDTH{1'b0}};
                valid <= 1'b0;
            end else if (en) begin
                if (fc_r >= deff_s) begin
                    O     <= mem_r[ra_s];
                    valid <= 1'b1;
                end else begin
                    O     <= {WIDTH{1'b0}};
                    valid <= 1'b0;
                end
                wp_r <= wp_nxt_s;
                fc_r <= fc_nxt_s;
            end
        end
    end

endmodule
